alu4_bist: RTL and testbench
============================

# alu4_bist

Built-in self-test initiator for the 4-bit `ALU4` datapath. It drives the ALU's operand and function pins, sweeps every logic function and the full add/subtract operand space, and compares each result against an internal golden model. It counts mismatches and reports pass/fail. It sits beside `ALU4` in the datapath and is muxed onto the ALU pins by the integration level when a test is requested.

## Interface
Parameters:
- `SETTLE`, default 1: wait cycles between driving a vector and sampling the ALU response. Range 0–7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  run request, sampled only in IDLE.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next accepted `start` or `rst`.
- `pass`  out  1  valid when `done`; 1 if `err_cnt`==0.
- `err_cnt`  out  8  mismatching vectors, saturates at 255.
- `fail_phase`  out  2  phase of the first mismatch: 0 LOGIC, 1 ADD, 2 SUB.
- `fail_idx`  out  8  vector index of the first mismatch.
- `alu_a`, `alu_b`  out  4  ALU operands.
- `alu_cin`  out  1  ALU carry in.
- `alu_m`  out  1  ALU mode.
- `alu_s`  out  4  ALU function select.
- `alu_do`  in  4  ALU result.
- `alu_co`, `alu_v`, `alu_z`  in  1  ALU carry, overflow and zero flags.

## Operation
- FSM states: IDLE → RUN → FIN → IDLE.
  - IDLE + `start` → RUN. This clears `err_cnt`, `fail_*`, `done` and `pass`.
  - RUN proceeds through phases LOGIC, ADD, SUB.
  - After the last SUB compare, the FSM enters FIN for one cycle, then returns to IDLE with `done`=1.
- LOGIC phase, 16 vectors, idx = function code:
  - `alu_a`=1100, `alu_b`=1010, `alu_cin`=1, `alu_m`=0, `alu_s`=idx.
  - Expected results by code: 0 → 0000; 1 → ~(A|B); 2 → ~A&B; 3 → ~A; 4 → A&~B; 5 → ~B; 6 → A^B; 7 → ~(A&B); 8 → A&B; 9 → ~(A^B); 10 → B; 11 → ~A|B; 12 → A; 13 → A|~B; 14 → A|B; 15 → 1111.
- ADD phase, 256 vectors:
  - `{alu_a,alu_b}`=idx, `alu_s`=1001, `alu_m`=1, `alu_cin`=0.
  - Expected `do`=(A+B)[3:0], `co`=(A+B)[4], V = signed overflow of A+B.
- SUB phase, 256 vectors:
  - `{alu_a,alu_b}`=idx, `alu_s`=0110, `alu_m`=1, `alu_cin`=1.
  - Expected `do`=(A−B)[3:0], `co`=(A+~B+1)[4] (1 when A≥B unsigned), V = signed overflow of A−B.
- Z expected = (expected `do`==0), in all phases.
- A vector mismatches if any compared field differs. Each mismatching vector adds 1 to `err_cnt`, with saturation.
- `fail_phase`/`fail_idx` are latched only on the first mismatch of a run.
- `start` while `busy` is ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_phase`=0, `fail_idx`=0, `alu_*`=0. The FSM is in IDLE.
- Cycle after `start` is accepted: vector 0 is on the `alu_*` pins (registered outputs), and `busy`=1.
- Each vector occupies SETTLE+1 cycles. The response is compared on the last cycle of the window, and the next vector is driven on the following cycle.
- The phase boundary has no gap: SUB idx 0 follows LOGIC/ADD directly.
- Full run is 528×(SETTLE+1) cycles from the first drive cycle to the final compare.
- `busy` falls and `done`/`pass` rise in the cycle after the final compare (FIN).
- `rst` mid-run: the next cycle is IDLE, all outputs take their reset values, and results are discarded.

## Configuration
- `ALU4_BIST_FLAGS_EN` defined: `alu_co`, `alu_v` and `alu_z` are compared in addition to `alu_do`.
- Undefined: only `alu_do` is compared. The flag inputs are ignored and may be left unconnected.

## Structure
- Package `alu4_bist_pkg` holds:
  - the phase enum (LOGIC/ADD/SUB);
  - FSM state typedef;
  - constants `S_ADD`=1001, `S_SUB`=0110, `LOGIC_A`=1100, `LOGIC_B`=1010;
  - vector counts 16/256.
- One sub-module, `alu4_bist_ref`: combinational golden model that maps (phase, a, b, s) to the expected do/co/v/z.

## Test plan
- Correct `ALU4` attached, SETTLE=1, `start` pulse → `done` after 1056 cycles, `pass`=1, `err_cnt`=0.
- `alu_do[0]` forced to 0 → 264 mismatching vectors (8+128+128), so `err_cnt`=255 (saturated); `fail_phase`=0, `fail_idx`=1; `pass`=0.
- `alu_co` inverted, macro defined → first fail is ADD idx 0, `err_cnt`=255. With macro undefined → `pass`=1.
- SETTLE=3 → `done` 2112 cycles after the first drive cycle; vector changes every 4 cycles.
- `start` re-pulsed while `busy` → ignored, run length unchanged. `rst` at cycle 300 → all outputs 0 the next cycle; a new `start` completes a full clean run.

Source files
------------

// File: rtl/alu4_bist_pkg.sv
// ============================================================================
// Module      : alu4_bist_pkg
// Description : Shared types and constants for the ALU4 built-in self-test:
//               phase and FSM state enums, fixed operand/function codes,
//               vector counts and the vector builder used by the initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu4_bist_pkg;

  // Test phases, numbered as reported on fail_phase
  typedef enum logic [1:0] {
    PH_LOGIC = 2'd0,
    PH_ADD   = 2'd1,
    PH_SUB   = 2'd2
  } phase_e;

  // Initiator control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // ALU function selects for the arithmetic sweeps
  localparam logic [3:0] S_ADD   = 4'b1001;
  localparam logic [3:0] S_SUB   = 4'b0110;

  // Fixed operands for the logic-function sweep
  localparam logic [3:0] LOGIC_A = 4'b1100;
  localparam logic [3:0] LOGIC_B = 4'b1010;

  // Vectors per phase
  localparam int unsigned N_LOGIC = 16;
  localparam int unsigned N_ARITH = 256;

  localparam logic [7:0] LAST_LOGIC_IDX = 8'(N_LOGIC - 1);
  localparam logic [7:0] LAST_ARITH_IDX = 8'(N_ARITH - 1);

  // One set of values for the ALU input pins
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       m;
    logic [3:0] s;
  } vec_t;

  // Build the ALU pin values for vector idx of phase ph
  function automatic vec_t make_vec(input phase_e ph, input logic [7:0] idx);
    vec_t v;
    v = '0;
    case (ph)
      PH_LOGIC: begin
        v.a   = LOGIC_A;
        v.b   = LOGIC_B;
        v.cin = 1'b1;
        v.m   = 1'b0;
        v.s   = idx[3:0];
      end
      PH_ADD: begin
        v.a   = idx[7:4];
        v.b   = idx[3:0];
        v.cin = 1'b0;
        v.m   = 1'b1;
        v.s   = S_ADD;
      end
      PH_SUB: begin
        v.a   = idx[7:4];
        v.b   = idx[3:0];
        v.cin = 1'b1;
        v.m   = 1'b1;
        v.s   = S_SUB;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu4_bist_ref.sv
// ============================================================================
// Module      : alu4_bist_ref
// Description : Combinational golden model of the ALU4 for the vectors the
//               self-test applies. Maps (phase, a, b, s) to the expected
//               result and carry/overflow/zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu4_bist_ref
  import alu4_bist_pkg::*;
(
  input  phase_e     phase_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] s_i,
  output logic [3:0] exp_do_o,
  output logic       exp_co_o,
  output logic       exp_v_o,
  output logic       exp_z_o
);

  logic [4:0] sum;

  // Expected ALU response for the current phase and operands
  always_comb begin
    sum      = 5'd0;
    exp_do_o = 4'd0;
    exp_co_o = 1'b0;
    exp_v_o  = 1'b0;
    case (phase_i)
      PH_LOGIC: begin
        case (s_i)
          4'd0:    exp_do_o = 4'b0000;
          4'd1:    exp_do_o = ~(a_i | b_i);
          4'd2:    exp_do_o = ~a_i & b_i;
          4'd3:    exp_do_o = ~a_i;
          4'd4:    exp_do_o = a_i & ~b_i;
          4'd5:    exp_do_o = ~b_i;
          4'd6:    exp_do_o = a_i ^ b_i;
          4'd7:    exp_do_o = ~(a_i & b_i);
          4'd8:    exp_do_o = a_i & b_i;
          4'd9:    exp_do_o = ~(a_i ^ b_i);
          4'd10:   exp_do_o = b_i;
          4'd11:   exp_do_o = ~a_i | b_i;
          4'd12:   exp_do_o = a_i;
          4'd13:   exp_do_o = a_i | ~b_i;
          4'd14:   exp_do_o = a_i | b_i;
          default: exp_do_o = 4'b1111;
        endcase
      end
      PH_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        exp_do_o = sum[3:0];
        exp_co_o = sum[4];
        // Like-signed operands producing an opposite-signed sum
        exp_v_o  = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
      end
      PH_SUB: begin
        // Two's-complement subtract so carry out means A >= B unsigned
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
        exp_do_o = sum[3:0];
        exp_co_o = sum[4];
        // Unlike-signed operands where the result sign departs from A
        exp_v_o  = (a_i[3] != b_i[3]) && (sum[3] != a_i[3]);
      end
      default: begin
        exp_do_o = 4'd0;
      end
    endcase
    exp_z_o = (exp_do_o == 4'd0);
  end

endmodule

`default_nettype wire

// File: rtl/alu4_bist.sv
// ============================================================================
// Module      : alu4_bist
// Description : Built-in self-test initiator for the 4-bit ALU4 datapath.
//               Sweeps all 16 logic functions, then the full add and
//               subtract operand spaces, compares each ALU response with
//               alu4_bist_ref, counts mismatches (saturating) and latches
//               the phase/index of the first one.
//               Build option ALU4_BIST_FLAGS_EN: also compare the carry,
//               overflow and zero flags (otherwise only the result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu4_bist
  import alu4_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [1:0] fail_phase,
  output logic [7:0] fail_idx,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic       alu_m,
  output logic [3:0] alu_s,
  input  logic [3:0] alu_do,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z
);

  localparam logic [2:0] SETTLE_W = 3'(SETTLE);

`ifdef ALU4_BIST_FLAGS_EN
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam logic FLAGS_EN = 1'b0;
`endif

  state_e     state_q,  state_d;
  phase_e     phase_q,  phase_d;
  logic [7:0] idx_q,    idx_d;
  logic [2:0] wait_q,   wait_d;
  logic       busy_q,   busy_d;
  logic       done_q,   done_d;
  logic       pass_q,   pass_d;
  logic [7:0] err_q,    err_d;
  logic [1:0] fphase_q, fphase_d;
  logic [7:0] fidx_q,   fidx_d;
  vec_t       vec_q,    vec_d;

  logic [3:0] exp_do;
  logic       exp_co;
  logic       exp_v;
  logic       exp_z;
  logic       cmp_arith_flags;
  logic       cmp_z;
  logic       mismatch;
  logic       last_in_phase;
  logic       last_vec;

  // The reference follows the registered vector, i.e. what the ALU sees
  alu4_bist_ref u_ref (
    .phase_i  (phase_q),
    .a_i      (vec_q.a),
    .b_i      (vec_q.b),
    .s_i      (vec_q.s),
    .exp_do_o (exp_do),
    .exp_co_o (exp_co),
    .exp_v_o  (exp_v),
    .exp_z_o  (exp_z)
  );

  // Compare the ALU response; carry/overflow have no meaning in logic mode
  always_comb begin
    cmp_arith_flags = FLAGS_EN && (phase_q != PH_LOGIC);
    cmp_z           = FLAGS_EN;
    mismatch        = (alu_do != exp_do)
                    | (cmp_arith_flags & ((alu_co != exp_co) | (alu_v != exp_v)))
                    | (cmp_z & (alu_z != exp_z));
  end

  // Position of the current vector within the sweep
  always_comb begin
    last_in_phase = (phase_q == PH_LOGIC) ? (idx_q == LAST_LOGIC_IDX)
                                          : (idx_q == LAST_ARITH_IDX);
    last_vec      = (phase_q == PH_SUB) && last_in_phase;
  end

  // Next-state, vector sequencing and result bookkeeping
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fphase_d = fphase_q;
    fidx_d   = fidx_q;
    vec_d    = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          phase_d  = PH_LOGIC;
          idx_d    = 8'd0;
          wait_d   = 3'd0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = 8'd0;
          fphase_d = 2'd0;
          fidx_d   = 8'd0;
          vec_d    = make_vec(PH_LOGIC, 8'd0);
        end
      end
      ST_RUN: begin
        if (wait_q == SETTLE_W) begin
          // Last cycle of the window: sample the response
          if (mismatch) begin
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
            if (err_q == 8'd0) begin
              fphase_d = phase_q;
              fidx_d   = idx_q;
            end
          end
          wait_d = 3'd0;
          if (last_vec) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 8'd0);
          end else if (last_in_phase) begin
            // Phases abut: index 0 of the next phase follows immediately
            phase_d = (phase_q == PH_LOGIC) ? PH_ADD : PH_SUB;
            idx_d   = 8'd0;
            vec_d   = make_vec(phase_d, 8'd0);
          end else begin
            idx_d = idx_q + 8'd1;
            vec_d = make_vec(phase_q, idx_d);
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_LOGIC;
      idx_q    <= 8'd0;
      wait_q   <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 8'd0;
      fphase_q <= 2'd0;
      fidx_q   <= 8'd0;
      vec_q    <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fphase_q <= fphase_d;
      fidx_q   <= fidx_d;
      vec_q    <= vec_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_phase = fphase_q;
  assign fail_idx   = fidx_q;
  assign alu_a      = vec_q.a;
  assign alu_b      = vec_q.b;
  assign alu_cin    = vec_q.cin;
  assign alu_m      = vec_q.m;
  assign alu_s      = vec_q.s;

endmodule

`default_nettype wire

// File: tb/tb_alu4_bist.sv
// ============================================================================
// Module      : tb_alu4_bist
// Description : Self-checking bench for alu4_bist. Two initiators (SETTLE=1
//               and SETTLE=3) each drive a behavioural ALU4 with optional
//               planted faults; a run-level model predicts pins, timing and
//               results, checked every cycle, plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu4_bist;

`ifdef ALU4_BIST_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_w;
  logic [1:0] busy_w, done_w, pass_w, alu_cin_w, alu_m_w;
  logic [1:0] alu_co_w, alu_v_w, alu_z_w;
  logic [1:0][7:0] err_w, fidx_w;
  logic [1:0][1:0] fph_w;
  logic [1:0][3:0] alu_a_w, alu_b_w, alu_s_w, alu_do_w;
  bit   [1:0] fdo0, fco;
  bit         chk_en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  alu4_bist #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_cnt(err_w[0]), .fail_phase(fph_w[0]), .fail_idx(fidx_w[0]),
    .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_cin(alu_cin_w[0]), .alu_m(alu_m_w[0]),
    .alu_s(alu_s_w[0]), .alu_do(alu_do_w[0]), .alu_co(alu_co_w[0]), .alu_v(alu_v_w[0]),
    .alu_z(alu_z_w[0])
  );

  alu4_bist #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_cnt(err_w[1]), .fail_phase(fph_w[1]), .fail_idx(fidx_w[1]),
    .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_cin(alu_cin_w[1]), .alu_m(alu_m_w[1]),
    .alu_s(alu_s_w[1]), .alu_do(alu_do_w[1]), .alu_co(alu_co_w[1]), .alu_v(alu_v_w[1]),
    .alu_z(alu_z_w[1])
  );

  // Behavioural ALU4: returns {co, v, z, do}
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic m, input logic [3:0] s);
    logic [4:0] r;
    logic [3:0] d;
    logic co, v;
    r = 5'd0; d = 4'd0; co = 1'b0; v = 1'b0;
    if (!m) begin
      case (s)
        4'd0:  d = 4'b0000;     4'd1:  d = ~(a | b);
        4'd2:  d = ~a & b;      4'd3:  d = ~a;
        4'd4:  d = a & ~b;      4'd5:  d = ~b;
        4'd6:  d = a ^ b;       4'd7:  d = ~(a & b);
        4'd8:  d = a & b;       4'd9:  d = ~(a ^ b);
        4'd10: d = b;           4'd11: d = ~a | b;
        4'd12: d = a;           4'd13: d = a | ~b;
        4'd14: d = a | b;       default: d = 4'b1111;
      endcase
    end else if (s == 4'b1001) begin
      r = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      d = r[3:0]; co = r[4];
      v = (a[3] == b[3]) && (d[3] != a[3]);
    end else if (s == 4'b0110) begin
      r = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
      d = r[3:0]; co = r[4];
      v = (a[3] != b[3]) && (d[3] != a[3]);
    end
    return {co, v, (d == 4'd0), d};
  endfunction

  logic [6:0] res0, res1;
  assign res0 = alu_fn(alu_a_w[0], alu_b_w[0], alu_cin_w[0], alu_m_w[0], alu_s_w[0]);
  assign res1 = alu_fn(alu_a_w[1], alu_b_w[1], alu_cin_w[1], alu_m_w[1], alu_s_w[1]);
  assign alu_do_w[0] = res0[3:0] & {3'b111, ~fdo0[0]};
  assign alu_do_w[1] = res1[3:0] & {3'b111, ~fdo0[1]};
  assign alu_co_w[0] = res0[6] ^ fco[0];
  assign alu_co_w[1] = res1[6] ^ fco[1];
  assign alu_v_w[0]  = res0[5];
  assign alu_v_w[1]  = res1[5];
  assign alu_z_w[0]  = (alu_do_w[0] == 4'd0);
  assign alu_z_w[1]  = (alu_do_w[1] == 4'd0);

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles per vector for each initiator
  function automatic int win(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  // Logic-function results for A=1100, B=1010
  function automatic int logic_ref(input int code);
    logic [3:0] A, B, r;
    A = 4'b1100; B = 4'b1010;
    case (code)
      0: r = 4'b0000;   1: r = ~(A | B);  2: r = ~A & B;    3: r = ~A;
      4: r = A & ~B;    5: r = ~B;        6: r = A ^ B;     7: r = ~(A & B);
      8: r = A & B;     9: r = ~(A ^ B);  10: r = B;        11: r = ~A | B;
      12: r = A;        13: r = A | ~B;   14: r = A | B;    default: r = 4'b1111;
    endcase
    return int'(r);
  endfunction

  // Expected pins {a,b,cin,m,s} for overall vector number n (0..527)
  function automatic int exp_vec(input int n);
    int a, b, cin, m, s, i;
    if (n < 16) begin
      a = 12; b = 10; cin = 1; m = 0; s = n;
    end else if (n < 272) begin
      i = n - 16; a = i / 16; b = i % 16; cin = 0; m = 1; s = 9;
    end else begin
      i = n - 272; a = i / 16; b = i % 16; cin = 1; m = 1; s = 6;
    end
    return (a << 10) | (b << 6) | (cin << 5) | (m << 4) | s;
  endfunction

  // Whole-run outcome under the planted faults: raw mismatch count and first failure
  function automatic void model_run(input bit f_do0, input bit f_co, input bit flags,
                                    output int raw, output int ph, output int ix);
    raw = 0; ph = 0; ix = 0;
    for (int n = 0; n < 528; n++) begin
      int p, i, a, b, d;
      bit bad;
      if (n < 16) begin
        p = 0; i = n; d = logic_ref(i);
      end else if (n < 272) begin
        p = 1; i = n - 16; a = i / 16; b = i % 16; d = (a + b) % 16;
      end else begin
        p = 2; i = n - 272; a = i / 16; b = i % 16; d = (a - b + 16) % 16;
      end
      bad = (f_do0 && (d % 2 == 1)) || (f_co && flags && p != 0);
      if (bad) begin
        if (raw == 0) begin ph = p; ix = i; end
        raw++;
      end
    end
  endfunction

  // Run-level model per initiator
  bit m_run[2], m_fin[2], m_done[2], m_clear[2];
  int m_cyc[2], m_raw[2], m_ph[2], m_ix[2];

  always @(posedge clk) begin
    int r, p, x;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] <= 1'b0; m_fin[k] <= 1'b0; m_done[k] <= 1'b0;
        m_clear[k] <= 1'b1; m_cyc[k] <= 0;
      end else if (m_run[k]) begin
        if (m_cyc[k] == 528 * win(k) - 1) begin
          m_run[k] <= 1'b0; m_fin[k] <= 1'b1; m_done[k] <= 1'b1;
        end else begin
          m_cyc[k] <= m_cyc[k] + 1;
        end
      end else if (m_fin[k]) begin
        m_fin[k] <= 1'b0;
      end else if (start_w[k]) begin
        model_run(fdo0[k], fco[k], FLAGS, r, p, x);
        m_run[k] <= 1'b1; m_cyc[k] <= 0; m_done[k] <= 1'b0; m_clear[k] <= 1'b0;
        m_raw[k] <= r; m_ph[k] <= p; m_ix[k] <= x;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.busy", k), int'(busy_w[k]), int'(m_run[k]));
        chk($sformatf("u%0d.done", k), int'(done_w[k]), int'(m_done[k]));
        if (m_done[k]) begin
          chk($sformatf("u%0d.pass", k), int'(pass_w[k]), (m_raw[k] == 0) ? 1 : 0);
          chk($sformatf("u%0d.err_cnt", k), int'(err_w[k]), (m_raw[k] > 255) ? 255 : m_raw[k]);
          chk($sformatf("u%0d.fail_phase", k), int'(fph_w[k]), m_ph[k]);
          chk($sformatf("u%0d.fail_idx", k), int'(fidx_w[k]), m_ix[k]);
        end else begin
          chk($sformatf("u%0d.pass_low", k), int'(pass_w[k]), 0);
        end
        if (m_run[k]) begin
          chk($sformatf("u%0d.pins", k),
              int'({alu_a_w[k], alu_b_w[k], alu_cin_w[k], alu_m_w[k], alu_s_w[k]}),
              exp_vec(m_cyc[k] / win(k)));
        end
        if (m_clear[k]) begin
          chk($sformatf("u%0d.rst_pins", k),
              int'({alu_a_w[k], alu_b_w[k], alu_cin_w[k], alu_m_w[k], alu_s_w[k]}), 0);
          chk($sformatf("u%0d.rst_res", k),
              int'({err_w[k], fph_w[k], fidx_w[k]}), 0);
        end
      end
    end
  end

  // Cycles from the first drive cycle (current negedge) until done is seen
  task automatic measure(input int k, output int lat);
    lat = 0;
    while (!done_w[k] && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pulse(input logic [1:0] which);
    start_w = which;
    @(negedge clk);
    start_w = 2'b00;
  endtask

  int lat0, lat1, r, p, x;

  initial begin
    rst = 1'b1; start_w = 2'b00; fdo0 = 2'b00; fco = 2'b00;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("reset.busy", int'(busy_w[0]), 0);
    chk("reset.done", int'(done_w[0]), 0);
    chk("reset.pass", int'(pass_w[0]), 0);
    chk("reset.err_cnt", int'(err_w[0]), 0);

    // Pin the model with hand-derived numbers
    chk("model.logic6", logic_ref(6), 6);
    chk("model.logic11", logic_ref(11), 11);
    model_run(1'b1, 1'b0, 1'b0, r, p, x);
    chk("model.do0_raw", r, 264);
    chk("model.do0_idx", x, 1);
    model_run(1'b0, 1'b1, 1'b1, r, p, x);
    chk("model.co_raw", r, 512);
    chk("model.co_phase", p, 1);
    model_run(1'b0, 1'b0, 1'b1, r, p, x);
    chk("model.clean_raw", r, 0);

    // Clean run on both initiators; re-pulse start mid-run on the first
    pulse(2'b11);
    fork
      measure(0, lat0);
      measure(1, lat1);
      begin
        repeat (100) @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
      end
    join
    chk("clean.latency_s1", lat0, 1056);
    chk("clean.latency_s3", lat1, 2112);
    chk("clean.pass", int'(pass_w[0]), 1);
    chk("clean.err_cnt", int'(err_w[0]), 0);
    repeat (3) @(negedge clk);

    // Result bit 0 stuck low
    fdo0[0] = 1'b1;
    pulse(2'b01);
    measure(0, lat0);
    chk("do0.latency", lat0, 1056);
    chk("do0.err_cnt", int'(err_w[0]), 255);
    chk("do0.fail_phase", int'(fph_w[0]), 0);
    chk("do0.fail_idx", int'(fidx_w[0]), 1);
    chk("do0.pass", int'(pass_w[0]), 0);
    fdo0[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Carry flag inverted
    fco[0] = 1'b1;
    pulse(2'b01);
    measure(0, lat0);
    chk("co.err_cnt", int'(err_w[0]), FLAGS ? 255 : 0);
    chk("co.fail_phase", int'(fph_w[0]), FLAGS ? 1 : 0);
    chk("co.fail_idx", int'(fidx_w[0]), 0);
    chk("co.pass", int'(pass_w[0]), FLAGS ? 0 : 1);
    fco[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-run, then a fresh clean run
    fdo0[0] = 1'b1;
    pulse(2'b01);
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.busy", int'(busy_w[0]), 0);
    chk("midrst.done", int'(done_w[0]), 0);
    chk("midrst.err_cnt", int'(err_w[0]), 0);
    chk("midrst.pins", int'({alu_a_w[0], alu_b_w[0], alu_cin_w[0], alu_m_w[0], alu_s_w[0]}), 0);
    fdo0[0] = 1'b0;
    @(negedge clk);
    pulse(2'b01);
    measure(0, lat0);
    chk("rerun.latency", lat0, 1056);
    chk("rerun.pass", int'(pass_w[0]), 1);
    chk("rerun.err_cnt", int'(err_w[0]), 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
